// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath.
//   aes_state_t    : 128-bit state, byte b = state[127-8b -: 8], column c = bytes 4c..4c+3
//   aes_word_t     : 32-bit column
//   iss_fsm_t      : control states of the iterative InvShiftRows/InvSubBytes stage
//   inv_shift_rows : row r of every column is rotated right by r columns
package aes_pkg;

    localparam int AES_NB    = 4;
    localparam int AES_BYTES = 16;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } iss_fsm_t;

    // out[4c+r] = in[4((c-r) mod 4)+r]
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t r;
        r = '0;
        for (int c = 0; c < AES_NB; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+AES_NB)%AES_NB)+row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_sbox_word.sv
// Inverse AES S-box applied to the four bytes of one 32-bit column.
// Purely combinational.
//   word  : input column, byte 0 in word[31:24]
//   subst : InvSubBytes of each byte, same byte order
module aes_inv_sbox_word
    import aes_pkg::*;
(
    input  aes_word_t word,
    output aes_word_t subst
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign subst[31:24] = INV_SBOX[word[31:24]];
    assign subst[23:16] = INV_SBOX[word[23:16]];
    assign subst[15:8]  = INV_SBOX[word[15:8]];
    assign subst[7:0]   = INV_SBOX[word[7:0]];

endmodule

// File: rtl/aes_inv_shift_sub.sv
// Iterative InvShiftRows + InvSubBytes stage of the AES decryption datapath.
// InvShiftRows is applied while capturing the state; InvSubBytes then runs
// NUM_SBOX_WORDS columns per cycle (4/NUM_SBOX_WORDS cycles) through shared
// S-box words, writing results back into the same state register.
//   clk, reset                      : clock (rising edge), async active-high reset
//   in_valid / in_ready             : upstream handshake; in_ready only in IDLE
//   in_state [127:0], in_tag        : state to process and its opaque sideband
//   out_valid / out_ready           : downstream handshake; held in DONE until taken
//   out_state [127:0], out_tag      : InvSubBytes(InvShiftRows(in_state)) and captured tag
module aes_inv_shift_sub
    import aes_pkg::*;
#(
    parameter int NUM_SBOX_WORDS = 1,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_state,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic [TAG_W-1:0] out_tag
);

    localparam int         GROUPS     = AES_NB / NUM_SBOX_WORDS;
    localparam logic [1:0] LAST_GROUP = 2'(GROUPS - 1);

    if (!(NUM_SBOX_WORDS == 1 || NUM_SBOX_WORDS == 2 || NUM_SBOX_WORDS == 4)) begin : g_bad_param
        $error("aes_inv_shift_sub: NUM_SBOX_WORDS must be 1, 2 or 4 (got %0d)", NUM_SBOX_WORDS);
    end

    iss_fsm_t         fsm, fsm_next;
    aes_state_t       state_reg, state_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic [1:0]       group, group_next;

    aes_word_t                              cols    [AES_NB];
    logic [1:0]                             col_sel [NUM_SBOX_WORDS];
    logic [NUM_SBOX_WORDS-1:0][31:0]        sbox_in;
    logic [NUM_SBOX_WORDS-1:0][31:0]        sbox_out;

    // Column view of the state register and selection of the current group.
    always_comb begin
        for (int c = 0; c < AES_NB; c++) begin
            cols[c] = state_reg[127-32*c -: 32];
        end
        for (int i = 0; i < NUM_SBOX_WORDS; i++) begin
            col_sel[i] = 2'(int'(group) * NUM_SBOX_WORDS + i);
            sbox_in[i] = cols[col_sel[i]];
        end
    end

    for (genvar i = 0; i < NUM_SBOX_WORDS; i++) begin : g_sbox
        aes_inv_sbox_word u_sbox (
            .word  (sbox_in[i]),
            .subst (sbox_out[i])
        );
    end

    always_comb begin
        fsm_next   = fsm;
        state_next = state_reg;
        tag_next   = tag_reg;
        group_next = group;
        case (fsm)
            IDLE: begin
                if (in_valid) begin
                    state_next = inv_shift_rows(in_state);
                    tag_next   = in_tag;
                    group_next = '0;
                    fsm_next   = SUB;
                end
            end
            SUB: begin
                for (int i = 0; i < NUM_SBOX_WORDS; i++) begin
                    state_next[127-32*int'(col_sel[i]) -: 32] = sbox_out[i];
                end
                if (group == LAST_GROUP) begin
                    group_next = '0;
                    fsm_next   = DONE;
                end else begin
                    group_next = group + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm       <= IDLE;
            state_reg <= '0;
            tag_reg   <= '0;
            group     <= '0;
        end else begin
            fsm       <= fsm_next;
            state_reg <= state_next;
            tag_reg   <= tag_next;
            group     <= group_next;
        end
    end

    // Handshake outputs decode only the registered FSM state.
    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign out_state = state_reg;
    assign out_tag   = tag_reg;

endmodule

// File: tb/tb_aes_inv_shift_sub.sv
// Bench for aes_inv_shift_sub: three instances (NUM_SBOX_WORDS = 1, 2, 4)
// checked against a reference built from the AES field arithmetic.
module tb_aes_inv_shift_sub;

    localparam int TAG_W = 4;
    localparam int NDUT  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid  [NDUT];
    logic             in_ready  [NDUT];
    logic [127:0]     in_state  [NDUT];
    logic [TAG_W-1:0] in_tag    [NDUT];
    logic             out_valid [NDUT];
    logic             out_ready [NDUT];
    logic [127:0]     out_state [NDUT];
    logic [TAG_W-1:0] out_tag   [NDUT];

    int errors = 0;
    int checks = 0;

    logic [7:0] inv_tbl [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int NW = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        aes_inv_shift_sub #(.NUM_SBOX_WORDS(NW), .TAG_W(TAG_W)) dut (
            .clk       (clk),
            .reset     (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_tag    (in_tag[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .out_tag   (out_tag[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // Forward S-box = affine(GF inverse); inverse table is its inverse permutation.
    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_model(input logic [127:0] s);
        logic [127:0] r;
        int c, row, src;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            c = b / 4; row = b % 4;
            src = 4 * ((c - row + 4) % 4) + row;
            r[127-8*b -: 8] = inv_tbl[s[127-8*src -: 8]];
        end
        return r;
    endfunction

    // Send one state on DUT d, wait for the result with out_ready=1, take it.
    task automatic run_one(input int d, input logic [127:0] st, input logic [TAG_W-1:0] tg,
                           output logic [127:0] res, output logic [TAG_W-1:0] rtag, output int lat,
                           output logic post_in_ready, output logic post_out_valid);
        logic acc, rdy;
        in_state[d] = st; in_tag[d] = tg; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
        acc = 1'b0; lat = -1;
        for (int i = 0; i < 20 && !acc; i++) begin
            rdy = in_ready[d];
            @(posedge clk); #1;
            acc = rdy;
        end
        in_valid[d] = 1'b0;
        checks++;
        if (acc !== 1'b1) begin
            errors++; $display("FAIL accept_dut%0d: accepted=%b required=1", d, acc);
        end
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (out_valid[d]) lat = i;
        end
        checks++;
        if (lat < 0) begin
            errors++; $display("FAIL out_valid_timeout_dut%0d: no out_valid within 20 cycles", d);
        end
        res = out_state[d]; rtag = out_tag[d];
        @(posedge clk); #1;
        post_in_ready = in_ready[d]; post_out_valid = out_valid[d];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d] = 1'b0; in_state[d] = '0; in_tag[d] = '0; out_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks += 4;
            if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready_dut%0d: got %b want 1", d, in_ready[d]); end
            if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid_dut%0d: got %b want 0", d, out_valid[d]); end
            if (out_state[d] !== 128'h0) begin errors++; $display("FAIL reset_out_state_dut%0d: got %h want 0", d, out_state[d]); end
            if (out_tag[d] !== '0) begin errors++; $display("FAIL reset_out_tag_dut%0d: got %h want 0", d, out_tag[d]); end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_state();
        logic [127:0] res; logic [TAG_W-1:0] rt; int lat; logic pir, pov;
        run_one(0, 128'h0, 4'd3, res, rt, lat, pir, pov);
        checks += 3;
        if (res !== {16{8'h52}}) begin errors++; $display("FAIL zero_state: got %h want %h", res, {16{8'h52}}); end
        if (rt !== 4'd3) begin errors++; $display("FAIL zero_tag: got %0d want 3", rt); end
        if (lat !== 4) begin errors++; $display("FAIL zero_latency: got %0d want 4", lat); end
    endtask

    task automatic test_latency_widths();
        logic [127:0] st, res; logic [TAG_W-1:0] rt; int lat; logic pir, pov;
        st = 128'h000102030405060708090a0b0c0d0e0f;
        for (int d = 0; d < NDUT; d++) begin
            run_one(d, st, 4'(9 + d), res, rt, lat, pir, pov);
            checks += 4;
            if (res[127:96] !== 32'h52f3a338) begin errors++; $display("FAIL col0_dut%0d: got %h want 52f3a338", d, res[127:96]); end
            if (res !== ref_model(st)) begin errors++; $display("FAIL counting_dut%0d: got %h want %h", d, res, ref_model(st)); end
            if (lat !== (4 >> d)) begin errors++; $display("FAIL latency_dut%0d: got %0d want %0d", d, lat, 4 >> d); end
            if (rt !== 4'(9 + d)) begin errors++; $display("FAIL counting_tag_dut%0d: got %0d want %0d", d, rt, 9 + d); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vec [10];
        logic [127:0] res; logic [TAG_W-1:0] rt; int lat; logic pir, pov;
        vec[0] = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
        vec[9] = 128'h6353e08c0960e104cd70b751bacad0e7;
        for (int k = 1; k < 9; k++) vec[k] = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 10; k++) begin
            run_one(0, vec[k], 4'(k), res, rt, lat, pir, pov);
            checks += 4;
            if (res !== ref_model(vec[k])) begin errors++; $display("FAIL b2b_state_%0d: got %h want %h", k, res, ref_model(vec[k])); end
            if (rt !== 4'(k)) begin errors++; $display("FAIL b2b_tag_%0d: got %0d want %0d", k, rt, k); end
            if (pir !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d: got %b want 1", k, pir); end
            if (pov !== 1'b0) begin errors++; $display("FAIL b2b_out_valid_%0d: got %b want 0", k, pov); end
            if (k == 0) begin
                checks++;
                if (res !== 128'hbd6e7c3df2b5779e0b61216e8b10b689) begin errors++; $display("FAIL fips_round1: got %h want bd6e7c3df2b5779e0b61216e8b10b689", res); end
            end
            if (k == 9) begin
                checks++;
                if (res !== 128'h00102030405060708090a0b0c0d0e0f0) begin errors++; $display("FAIL fips_round10: got %h want 00102030405060708090a0b0c0d0e0f0", res); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] st, exp; logic acc, rdy, seen;
        st = {$urandom, $urandom, $urandom, $urandom};
        exp = ref_model(st);
        out_ready[0] = 1'b0;
        in_state[0] = st; in_tag[0] = 4'd5; in_valid[0] = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin rdy = in_ready[0]; @(posedge clk); #1; acc = rdy; end
        in_valid[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin @(posedge clk); #1; seen = out_valid[0]; end
        checks++;
        if (!(acc && seen)) begin errors++; $display("FAIL bp_setup: accepted=%b out_valid=%b want 1 1", acc, seen); end
        for (int i = 0; i < 7; i++) begin
            in_valid[0] = 1'b1; in_state[0] = {$urandom, $urandom, $urandom, $urandom}; in_tag[0] = 4'd12;
            checks += 4;
            if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid_%0d: got %b want 1", i, out_valid[0]); end
            if (out_state[0] !== exp) begin errors++; $display("FAIL bp_state_%0d: got %h want %h", i, out_state[0], exp); end
            if (out_tag[0] !== 4'd5) begin errors++; $display("FAIL bp_tag_%0d: got %0d want 5", i, out_tag[0]); end
            if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready[0]); end
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid[0]); end
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready[0]); end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_ignored_input: out_valid=%b want 0", out_valid[0]); end
    endtask

    task automatic test_reset_mid_sub();
        logic [127:0] st, res; logic [TAG_W-1:0] rt; int lat; logic pir, pov, acc, rdy;
        in_state[0] = {$urandom, $urandom, $urandom, $urandom}; in_tag[0] = 4'd7; in_valid[0] = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin rdy = in_ready[0]; @(posedge clk); #1; acc = rdy; end
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks += 4;
        if (acc !== 1'b1) begin errors++; $display("FAIL midsub_accept: got %b want 1", acc); end
        if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL midsub_out_valid: got %b want 0", out_valid[0]); end
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL midsub_in_ready: got %b want 1", in_ready[0]); end
        if (out_state[0] !== 128'h0) begin errors++; $display("FAIL midsub_out_state: got %h want 0", out_state[0]); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        st = {$urandom, $urandom, $urandom, $urandom};
        run_one(0, st, 4'd2, res, rt, lat, pir, pov);
        checks += 3;
        if (res !== ref_model(st)) begin errors++; $display("FAIL after_reset_state: got %h want %h", res, ref_model(st)); end
        if (rt !== 4'd2) begin errors++; $display("FAIL after_reset_tag: got %0d want 2", rt); end
        if (lat !== 4) begin errors++; $display("FAIL after_reset_latency: got %0d want 4", lat); end
    endtask

    task automatic test_random(input int num);
        logic [127:0]     exp_q  [$];
        logic [TAG_W-1:0] expt_q [$];
        int got;
        got = 0;
        fork
            begin : producer
                logic [127:0] st; logic [TAG_W-1:0] tg; logic acc, rdy; int gap; logic stop;
                stop = 1'b0;
                for (int i = 0; i < num && !stop; i++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin @(posedge clk); #1; end
                    st = {$urandom, $urandom, $urandom, $urandom}; tg = 4'($urandom);
                    in_state[0] = st; in_tag[0] = tg; in_valid[0] = 1'b1;
                    acc = 1'b0;
                    for (int w = 0; w < 200 && !acc; w++) begin rdy = in_ready[0]; @(posedge clk); #1; acc = rdy; end
                    in_valid[0] = 1'b0;
                    if (acc) begin
                        exp_q.push_back(ref_model(st)); expt_q.push_back(tg);
                    end else begin
                        checks++; errors++; stop = 1'b1;
                        $display("FAIL rand_accept_timeout: item %0d not accepted", i);
                    end
                end
            end
            begin : consumer
                logic [127:0] e; logic [TAG_W-1:0] et;
                for (int cyc = 0; cyc < 60000 && got < num; cyc++) begin
                    out_ready[0] = ($urandom_range(0, 3) != 0);
                    if (out_valid[0] && out_ready[0]) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL rand_extra_result: unexpected state %h", out_state[0]);
                        end else begin
                            e = exp_q.pop_front(); et = expt_q.pop_front();
                            if (out_state[0] !== e || out_tag[0] !== et) begin
                                errors++;
                                $display("FAIL rand_result_%0d: got %h/%0d want %h/%0d", got, out_state[0], out_tag[0], e, et);
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                end
            end
        join
        out_ready[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks += 3;
        if (got !== num) begin errors++; $display("FAIL rand_count: got %0d results want %0d", got, num); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_dropped: %0d results missing", exp_q.size()); end
        if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL rand_trailing_valid: got %b want 0", out_valid[0]); end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_zero_state();
        test_latency_widths();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_sub();
        test_random(2000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
